// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 3-digit common-anode 7-segment driver for packed BCD input.
// New values are staged on load and only applied at frame wrap, so a frame never mixes two values.
module bcd_seg7_scanner #(
    parameter int unsigned RefreshDiv = 50000,
    parameter int unsigned BlankCyc   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] value_i,
    input  logic        load_i,
    input  logic        lz_blank_i,
    output logic [6:0]  seg_o,
    output logic [2:0]  anode_o,
    output logic        frame_done_o
);

    localparam int unsigned DivMax = (RefreshDiv > BlankCyc) ? RefreshDiv : BlankCyc;
    localparam int unsigned DivW   = (DivMax > 1) ? $clog2(DivMax) : 1;
    localparam logic [DivW-1:0] ShowLast  = DivW'(RefreshDiv - 1);
    localparam logic [DivW-1:0] BlankLast = DivW'(BlankCyc - 1);

    typedef enum logic [0:0] {
        StShow,
        StBlank
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      idx_q, idx_d;
    logic            wrap;

    logic [11:0]     shadow_q, shadow_d;
    logic [11:0]     pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;

    logic [6:0]      seg_q, seg_d;
    logic [2:0]      anode_q, anode_d;
    logic            frame_done_q, frame_done_d;

    logic [3:0]      digit;
    logic            lz_hit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Scan sequencer: SHOW each digit, then a dead-time BLANK before the next one.
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DivW'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        unique case (state_q)
            StShow: begin
                if (div_q == ShowLast) begin
                    state_d = StBlank;
                    div_d   = '0;
                end
            end
            StBlank: begin
                if (div_q == BlankLast) begin
                    state_d = StShow;
                    div_d   = '0;
                    idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    wrap    = (idx_q == 2'd2);
                end
            end
            default: begin
                state_d = StShow;
                div_d   = '0;
            end
        endcase
    end

    // A load coinciding with the wrap bypasses the pending register.
    always_comb begin
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (load_i) begin
            pend_d       = value_i;
            pend_valid_d = 1'b1;
        end
        if (wrap) begin
            if (load_i) begin
                shadow_d = value_i;
            end else if (pend_valid_q) begin
                shadow_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        case (idx_q)
            2'd1:    digit = shadow_q[7:4];
            2'd2:    digit = shadow_q[11:8];
            default: digit = shadow_q[3:0];
        endcase
        // Invalid nibbles are nonzero, so they stop leading-zero blanking.
        lz_hit = lz_blank_i &&
                 (((idx_q == 2'd2) && (shadow_q[11:8] == 4'd0)) ||
                  ((idx_q == 2'd1) && (shadow_q[11:8] == 4'd0) && (shadow_q[7:4] == 4'd0)));

        seg_d        = 7'h7F;
        anode_d      = 3'b111;
        frame_done_d = wrap;
        if (state_q == StShow) begin
            anode_d = ~(3'b001 << idx_q);
            seg_d   = lz_hit ? 7'h7F : decode(digit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StShow;
            div_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 12'h000;
            pend_q       <= 12'h000;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h7F;
            anode_q      <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign anode_o      = anode_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Self-checking bench for bcd_seg7_scanner: directed scenarios plus random loads/resets,
// checked every cycle against a frame-position model of the display.
module tb_bcd_seg7_scanner;

    localparam int unsigned Rd    = 4;
    localparam int unsigned Bc    = 1;
    localparam int unsigned Slot  = Rd + Bc;
    localparam int unsigned Frame = 3 * Slot;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        lz;
    logic [11:0] value;
    logic [6:0]  seg;
    logic [2:0]  anode;
    logic        fd;

    always #5 clk = ~clk;

    bcd_seg7_scanner #(
        .RefreshDiv (Rd),
        .BlankCyc   (Bc)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .value_i      (value),
        .load_i       (load),
        .lz_blank_i   (lz),
        .seg_o        (seg),
        .anode_o      (anode),
        .frame_done_o (fd)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          k     = 0;
    logic [11:0] m_shadow = '0;
    logic [11:0] m_pend   = '0;
    bit          m_pv     = 1'b0;
    logic [6:0]  e_seg;
    logic [2:0]  e_anode;
    logic        e_fd;
    logic [6:0]  seg_tab [16];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    // One clock: model the edge from the inputs the DUT sampled, then compare just after it.
    task automatic tick();
        int         pos;
        int         d;
        logic [3:0] nib;
        logic       blank;
        bit         wrap;
        @(posedge clk);
        if (rst) begin
            k        = 0;
            m_shadow = '0;
            m_pv     = 1'b0;
            e_seg    = 7'h7F;
            e_anode  = 3'b111;
            e_fd     = 1'b0;
        end else begin
            pos   = k % Frame;
            d     = pos / Slot;
            nib   = 4'((m_shadow >> (4 * d)) & 12'hF);
            blank = lz && (((d == 2) && (m_shadow[11:8] == 0)) ||
                           ((d == 1) && (m_shadow[11:8] == 0) && (m_shadow[7:4] == 0)));
            if ((pos % Slot) < Rd) begin
                e_anode = ~(3'(1) << d);
                e_seg   = blank ? 7'h7F : seg_tab[nib];
            end else begin
                e_anode = 3'b111;
                e_seg   = 7'h7F;
            end
            wrap = (pos == Frame - 1);
            e_fd = wrap;
            if (load && wrap) begin
                m_shadow = value;
                m_pv     = 1'b0;
            end else if (load) begin
                m_pend = value;
                m_pv   = 1'b1;
            end else if (wrap && m_pv) begin
                m_shadow = m_pend;
                m_pv     = 1'b0;
            end
            k++;
        end
        #1;
        check("seg", 12'(seg), 12'(e_seg));
        check("anode", 12'(anode), 12'(e_anode));
        check("frame_done", 12'(fd), 12'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [11:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
        value = 12'($urandom);
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < Frame && (k % Frame) != p; i++) tick();
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        for (int i = 0; i < 3; i++) begin
            v = v << 4;
            v[3:0] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        rst = 1'b1; load = 1'b0; lz = 1'b0; value = '0;
        run(3);
        rst = 1'b0;
        run(20);

        goto_pos(7);
        do_load(12'h129);
        run(2 * Frame);

        lz = 1'b1;
        do_load(12'h005);
        run(2 * Frame);
        lz = 1'b0;
        run(Frame);

        goto_pos(2);
        do_load(12'h111);
        run(3);
        do_load(12'h222);
        run(2 * Frame);

        goto_pos(Frame - 1);
        do_load(12'h3A7);
        run(2 * Frame);

        goto_pos(6);
        do_load(12'h456);
        run(2);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2 * Frame);

        for (int c = 0; c < 3000; c++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = load ? rand_bcd() : 12'($urandom);
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
